mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one memory bus between the CPU's instruction-fetch port and its load/store port.
//  Fixed-priority FSM: data over instruction. Grants one transaction at a time, latches it,
//  drives the shared request/response bus and routes acks/responses back to the requester.
//  Sits between the multicycle CPU control/datapath and the single-ported memory.
// PARAMETERS
//  ADDR_W  32  address width
//  DATA_W  32  data width (strobe width = DATA_W/8)
// PORTS
//  clk              in   1         clock; all logic on posedge
//  rst              in   1         synchronous, active-high reset
//  inst_req_valid   in   1         fetch request
//  inst_addr        in   ADDR_W    fetch address
//  inst_req_ack     out  1         fetch request accepted by memory
//  inst_valid       out  1         fetched word valid
//  inst_data        out  DATA_W    fetched word
//  inst_ack         in   1         CPU accepts fetched word
//  mem_read         in   1         load request
//  mem_write        in   1         store request
//  mem_addr         in   ADDR_W    load/store address
//  mem_wdata        in   DATA_W    store data
//  mem_wstrb        in   DATA_W/8  store byte strobes
//  mem_req_ack      out  1         load/store request accepted by memory
//  read_data_valid  out  1         load data valid
//  read_data        out  DATA_W    load data
//  read_data_ack    in   1         CPU accepts load data
//  bus_req_valid    out  1         shared bus request
//  bus_req_wr       out  1         1 = write, 0 = read
//  bus_addr         out  ADDR_W    latched address
//  bus_wdata        out  DATA_W    latched write data
//  bus_wstrb        out  DATA_W/8  latched strobes (0 for reads)
//  bus_req_ack      in   1         memory accepts request
//  bus_resp_valid   in   1         memory read data valid
//  bus_resp_data    in   DATA_W    memory read data
//  bus_resp_ack     out  1         arbiter/CPU accepts read data
// BEHAVIOUR
//  - States: IDLE, I_REQ, I_RESP, D_RD_REQ, D_RESP, D_WR_REQ. Reset -> IDLE.
//  - Reset values: state IDLE; bus_addr/bus_wdata/bus_wstrb/bus_req_wr 0; every valid/ack output 0.
//  - IDLE: mem_read|mem_write -> latch mem_addr/wdata/wstrb, go D_RD_REQ (read) or D_WR_REQ (write);
//    else inst_req_valid -> latch inst_addr, wstrb=0, go I_REQ. Data wins on simultaneous requests.
//    mem_read&mem_write together: treated as write.
//  - Latency: request sampled in IDLE at cycle N -> bus_req_valid=1 at cycle N+1.
//  - *_REQ states: bus_req_valid=1, bus_req_wr=1 only in D_WR_REQ; payload from latches, stable until ack.
//    Granted side's req ack = bus_req_ack (combinational); other side's ack 0.
//    bus_req_ack=1: I_REQ->I_RESP, D_RD_REQ->D_RESP, D_WR_REQ->IDLE (writes have no response phase).
//  - *_RESP: inst_valid / read_data_valid = bus_resp_valid of granted side only;
//    inst_data / read_data = bus_resp_data; bus_resp_ack = inst_ack (I_RESP) or read_data_ack (D_RESP).
//    Leave to IDLE on bus_resp_valid & bus_resp_ack.
//  - Outside RESP states bus_resp_ack=0; stray inst_ack/read_data_ack/bus_resp_valid ignored.
//  - Requester dropping its request after grant does not cancel; transaction completes.
//  - Back-to-back: one IDLE cycle between transactions minimum; no new grant in the completion cycle.
//  - rst mid-transaction: next cycle IDLE, all valid/ack outputs 0; in-flight transaction abandoned.
// CONFIGURATION
//  ARB_PERF_CNT_EN defined: adds outputs perf_inst_cnt, perf_data_cnt, perf_stall_cnt (32 bit each).
//    inst: +1 per completed fetch (I_RESP handshake); data: +1 per completed load (D_RESP handshake)
//    or store (D_WR_REQ ack); stall: +1 per cycle bus_req_valid & !bus_req_ack.
//    Reset to 0 by rst; wrap 0xFFFFFFFF -> 0.
//  Undefined: ports and counters absent; arbitration behaviour identical.
// TESTING
//  1 Fetch 0x0000_0100, bus_req_ack after 2 wait cycles, resp 0x0000_0013 -> inst_req_ack once,
//    inst_valid with inst_data=0x13, return IDLE; mem_req_ack never 1.
//  2 inst_req_valid and mem_read (addr 0x200) same cycle -> bus_addr=0x200 granted first, fetch served next.
//  3 Store addr 0x300 data 0xDEADBEEF strb 0xF -> bus_req_wr=1, bus_wstrb=0xF, IDLE after ack, no resp phase.
//  4 Load with bus_resp_valid held 3 cycles while read_data_ack=0 -> bus_resp_ack=0, state stays D_RESP
//    until ack; read_data held 0x12345678.
//  5 rst asserted in I_RESP -> next cycle IDLE, all valids/acks 0; new load then served normally.
//  6 ARB_PERF_CNT_EN: 2 fetches + 1 store, 3 stall cycles -> inst=2, data=1, stall=3; preload
//    0xFFFFFFFF -> wraps to 0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-ported memory bus between the CPU
// instruction-fetch port and its load/store port.
//
// - Fixed priority: a data request wins over a fetch request.
// - One transaction is in flight at a time. Its address, write data and
//   strobes are latched when it is granted.
// - Request acks and responses are routed back to the granted side only.
//
// Optional feature: define ARB_PERF_CNT_EN to add three 32-bit performance
// counters (perf_inst_cnt, perf_data_cnt, perf_stall_cnt). Arbitration
// behaviour is identical with or without the macro.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req_valid,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic                  inst_req_ack,
    output logic                  inst_valid,
    output logic [DATA_W-1:0]     inst_data,
    input  logic                  inst_ack,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W/8-1:0]   mem_wstrb,
    output logic                  mem_req_ack,
    output logic                  read_data_valid,
    output logic [DATA_W-1:0]     read_data,
    input  logic                  read_data_ack,
    output logic                  bus_req_valid,
    output logic                  bus_req_wr,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    output logic [DATA_W/8-1:0]   bus_wstrb,
    input  logic                  bus_req_ack,
    input  logic                  bus_resp_valid,
    input  logic [DATA_W-1:0]     bus_resp_data,
    output logic                  bus_resp_ack
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]           perf_inst_cnt,
    output logic [31:0]           perf_data_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_I_REQ    = 3'd1,
        ST_I_RESP   = 3'd2,
        ST_D_RD_REQ = 3'd3,
        ST_D_RESP   = 3'd4,
        ST_D_WR_REQ = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;

    // Latched payload is presented on the bus unchanged until the next grant.
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_wstrb = wstrb_q;

    // State and payload latches; rst abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            wstrb_q <= {STRB_W{1'b0}};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    // Grant selection, next state and handshake routing to the granted side.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        wstrb_d         = wstrb_q;
        bus_req_valid   = 1'b0;
        bus_req_wr      = 1'b0;
        inst_req_ack    = 1'b0;
        mem_req_ack     = 1'b0;
        inst_valid      = 1'b0;
        read_data_valid = 1'b0;
        bus_resp_ack    = 1'b0;
        inst_data       = {DATA_W{1'b0}};
        read_data       = {DATA_W{1'b0}};
        case (state_q)
            ST_IDLE: begin
                // Data side has priority; read+write together is a write.
                if (mem_read || mem_write) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    if (mem_write) begin
                        wstrb_d = mem_wstrb;
                        state_d = ST_D_WR_REQ;
                    end else begin
                        wstrb_d = {STRB_W{1'b0}};
                        state_d = ST_D_RD_REQ;
                    end
                end else if (inst_req_valid) begin
                    addr_d  = inst_addr;
                    wdata_d = {DATA_W{1'b0}};
                    wstrb_d = {STRB_W{1'b0}};
                    state_d = ST_I_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_I_REQ: begin
                bus_req_valid = 1'b1;
                inst_req_ack  = bus_req_ack;
                if (bus_req_ack) begin
                    state_d = ST_I_RESP;
                end else begin
                    state_d = ST_I_REQ;
                end
            end
            ST_I_RESP: begin
                inst_valid   = bus_resp_valid;
                inst_data    = bus_resp_data;
                bus_resp_ack = inst_ack;
                if (bus_resp_valid && inst_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_I_RESP;
                end
            end
            ST_D_RD_REQ: begin
                bus_req_valid = 1'b1;
                mem_req_ack   = bus_req_ack;
                if (bus_req_ack) begin
                    state_d = ST_D_RESP;
                end else begin
                    state_d = ST_D_RD_REQ;
                end
            end
            ST_D_RESP: begin
                read_data_valid = bus_resp_valid;
                read_data       = bus_resp_data;
                bus_resp_ack    = read_data_ack;
                if (bus_resp_valid && read_data_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_D_RESP;
                end
            end
            ST_D_WR_REQ: begin
                // Writes complete on the request handshake; there is no response phase.
                bus_req_valid = 1'b1;
                bus_req_wr    = 1'b1;
                mem_req_ack   = bus_req_ack;
                if (bus_req_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_D_WR_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef ARB_PERF_CNT_EN
    logic        inst_done_s;
    logic        data_done_s;
    logic        stall_s;
    logic [31:0] perf_inst_q;
    logic [31:0] perf_data_q;
    logic [31:0] perf_stall_q;

    assign perf_inst_cnt  = perf_inst_q;
    assign perf_data_cnt  = perf_data_q;
    assign perf_stall_cnt = perf_stall_q;

    // Completion and stall events observed on the current cycle.
    always_comb begin
        inst_done_s = 1'b0;
        data_done_s = 1'b0;
        stall_s     = bus_req_valid && !bus_req_ack;
        if (state_q == ST_I_RESP) begin
            inst_done_s = bus_resp_valid && inst_ack;
        end else if (state_q == ST_D_RESP) begin
            data_done_s = bus_resp_valid && read_data_ack;
        end else if (state_q == ST_D_WR_REQ) begin
            data_done_s = bus_req_ack;
        end else begin
            inst_done_s = 1'b0;
            data_done_s = 1'b0;
        end
    end

    // Free-running event counters; they wrap naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_inst_q  <= 32'd0;
            perf_data_q  <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (inst_done_s) begin
                perf_inst_q <= perf_inst_q + 32'd1;
            end
            if (data_done_s) begin
                perf_data_q <= perf_data_q + 32'd1;
            end
            if (stall_s) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter. Expected bus transactions and
// responses are queued when stimulus is driven. Observed handshakes are
// queued at the negative clock edge, and both queues are compared at the end.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_txn_t;

    typedef struct packed {
        logic        is_inst;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req_valid;
    logic [31:0] inst_addr;
    logic        inst_req_ack;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic        inst_ack;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_req_ack;
    logic        read_data_valid;
    logic [31:0] read_data;
    logic        read_data_ack;
    logic        bus_req_valid;
    logic        bus_req_wr;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_req_ack;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_data;
    logic        bus_resp_ack;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_inst_cnt;
    logic [31:0] perf_data_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    int ack_i_cnt = 0;
    int ack_d_cnt = 0;

    bus_txn_t exp_bus_q[$];
    bus_txn_t obs_bus_q[$];
    rsp_t     exp_rsp_q[$];
    rsp_t     obs_rsp_q[$];

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_req_valid  (inst_req_valid),
        .inst_addr       (inst_addr),
        .inst_req_ack    (inst_req_ack),
        .inst_valid      (inst_valid),
        .inst_data       (inst_data),
        .inst_ack        (inst_ack),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wstrb       (mem_wstrb),
        .mem_req_ack     (mem_req_ack),
        .read_data_valid (read_data_valid),
        .read_data       (read_data),
        .read_data_ack   (read_data_ack),
        .bus_req_valid   (bus_req_valid),
        .bus_req_wr      (bus_req_wr),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_wstrb       (bus_wstrb),
        .bus_req_ack     (bus_req_ack),
        .bus_resp_valid  (bus_resp_valid),
        .bus_resp_data   (bus_resp_data),
        .bus_resp_ack    (bus_resp_ack)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_inst_cnt   (perf_inst_cnt),
        .perf_data_cnt   (perf_data_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Records handshakes at the negedge, then advances to just after the next posedge.
    task automatic cyc();
        @(negedge clk);
        if (!rst) begin
            if (bus_req_valid && bus_req_ack)
                obs_bus_q.push_back('{bus_req_wr, bus_addr, bus_wdata, bus_wstrb});
            if (inst_valid && inst_ack)
                obs_rsp_q.push_back('{1'b1, inst_data});
            if (read_data_valid && read_data_ack)
                obs_rsp_q.push_back('{1'b0, read_data});
            if (inst_req_ack) ack_i_cnt++;
            if (mem_req_ack) ack_d_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req_valid = 1'b0; inst_addr = 32'd0; inst_ack = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = 32'd0;
        mem_wdata = 32'd0; mem_wstrb = 4'd0; read_data_ack = 1'b0;
        bus_req_ack = 1'b0; bus_resp_valid = 1'b0; bus_resp_data = 32'd0;
    endtask

    // Stimulus: a complete fetch with `waits` request stall cycles; starts and ends in IDLE.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input int waits);
        exp_bus_q.push_back('{1'b0, a, 32'd0, 4'd0});
        exp_rsp_q.push_back('{1'b1, d});
        inst_req_valid = 1'b1; inst_addr = a;
        cyc();
        inst_req_valid = 1'b0;
        repeat (waits) cyc();
        bus_req_ack = 1'b1;
        cyc();
        bus_req_ack = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = d; inst_ack = 1'b1;
        cyc();
        bus_resp_valid = 1'b0; inst_ack = 1'b0;
    endtask

    // Stimulus: a complete load with no request stall cycles.
    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        exp_bus_q.push_back('{1'b0, a, 32'd0, 4'd0});
        exp_rsp_q.push_back('{1'b0, d});
        mem_read = 1'b1; mem_addr = a;
        cyc();
        mem_read = 1'b0; bus_req_ack = 1'b1;
        cyc();
        bus_req_ack = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = d; read_data_ack = 1'b1;
        cyc();
        bus_resp_valid = 1'b0; read_data_ack = 1'b0;
    endtask

    // Stimulus: a complete store; `both` also raises mem_read, which must still be a write.
    task automatic do_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                            input int waits, input logic both);
        exp_bus_q.push_back('{1'b1, a, wd, ws});
        mem_write = 1'b1; mem_read = both; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
        cyc();
        mem_write = 1'b0; mem_read = 1'b0; mem_wdata = 32'd0; mem_wstrb = 4'd0;
        repeat (waits) cyc();
        bus_req_ack = 1'b1;
        cyc();
        bus_req_ack = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if ({bus_req_valid, bus_req_wr, inst_req_ack, mem_req_ack, inst_valid,
             read_data_valid, bus_resp_ack} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 0000000", {bus_req_valid, bus_req_wr,
                     inst_req_ack, mem_req_ack, inst_valid, read_data_valid, bus_resp_ack});
        end
        n_vec++;
        if ({bus_addr, bus_wdata, bus_wstrb} !== 68'd0) begin
            n_err++;
            $display("FAIL reset_payload: got %h/%h/%h expected 0", bus_addr, bus_wdata, bus_wstrb);
        end
    endtask

    task automatic test_fetch();
        ack_i_cnt = 0; ack_d_cnt = 0;
        exp_bus_q.push_back('{1'b0, 32'h0000_0100, 32'd0, 4'd0});
        exp_rsp_q.push_back('{1'b1, 32'h0000_0013});
        inst_req_valid = 1'b1; inst_addr = 32'h0000_0100;
        cyc();
        inst_req_valid = 1'b0; #1;
        n_vec++;
        if (bus_req_valid !== 1'b1 || bus_addr !== 32'h100 || bus_req_wr !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_latency: got v=%b a=%h wr=%b expected 1/100/0",
                     bus_req_valid, bus_addr, bus_req_wr);
        end
        cyc(); #1;
        n_vec++;
        if (bus_req_valid !== 1'b1 || bus_addr !== 32'h100 || inst_req_ack !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_wait: got v=%b a=%h ack=%b expected 1/100/0",
                     bus_req_valid, bus_addr, inst_req_ack);
        end
        cyc();
        bus_req_ack = 1'b1;
        cyc();
        bus_req_ack = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = 32'h13; inst_ack = 1'b1; #1;
        n_vec++;
        if (inst_valid !== 1'b1 || inst_data !== 32'h13 || bus_resp_ack !== 1'b1 || read_data_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_resp: got v=%b d=%h rack=%b rdv=%b expected 1/13/1/0",
                     inst_valid, inst_data, bus_resp_ack, read_data_valid);
        end
        cyc();
        bus_resp_valid = 1'b0; inst_ack = 1'b0; #1;
        n_vec++;
        if (bus_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_idle: got req=%b iv=%b expected 0/0", bus_req_valid, inst_valid);
        end
        n_vec++;
        if (ack_i_cnt !== 1 || ack_d_cnt !== 0) begin
            n_err++;
            $display("FAIL fetch_acks: got inst=%0d mem=%0d expected 1/0", ack_i_cnt, ack_d_cnt);
        end
    endtask

    task automatic test_priority();
        exp_bus_q.push_back('{1'b0, 32'h0000_0200, 32'd0, 4'd0});
        exp_rsp_q.push_back('{1'b0, 32'hAAAA_0001});
        exp_bus_q.push_back('{1'b0, 32'h0000_0400, 32'd0, 4'd0});
        exp_rsp_q.push_back('{1'b1, 32'h0000_0093});
        inst_req_valid = 1'b1; inst_addr = 32'h400; mem_read = 1'b1; mem_addr = 32'h200;
        cyc();
        mem_read = 1'b0; bus_req_ack = 1'b1; #1;
        n_vec++;
        if (bus_addr !== 32'h200 || mem_req_ack !== 1'b1 || inst_req_ack !== 1'b0) begin
            n_err++;
            $display("FAIL prio_grant: got a=%h mack=%b iack=%b expected 200/1/0",
                     bus_addr, mem_req_ack, inst_req_ack);
        end
        cyc();
        bus_req_ack = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = 32'hAAAA_0001; read_data_ack = 1'b1; #1;
        n_vec++;
        if (read_data_valid !== 1'b1 || inst_valid !== 1'b0 || read_data !== 32'hAAAA_0001) begin
            n_err++;
            $display("FAIL prio_resp: got rdv=%b iv=%b d=%h expected 1/0/aaaa0001",
                     read_data_valid, inst_valid, read_data);
        end
        cyc();
        bus_resp_valid = 1'b0; read_data_ack = 1'b0; #1;
        n_vec++;
        if (bus_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_gap: got req=%b expected 0", bus_req_valid);
        end
        cyc();
        inst_req_valid = 1'b0; bus_req_ack = 1'b1; #1;
        n_vec++;
        if (bus_req_valid !== 1'b1 || bus_addr !== 32'h400 || inst_req_ack !== 1'b1) begin
            n_err++;
            $display("FAIL prio_second: got v=%b a=%h iack=%b expected 1/400/1",
                     bus_req_valid, bus_addr, inst_req_ack);
        end
        cyc();
        bus_req_ack = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = 32'h93; inst_ack = 1'b1;
        cyc();
        bus_resp_valid = 1'b0; inst_ack = 1'b0;
    endtask

    task automatic test_store();
        exp_bus_q.push_back('{1'b1, 32'h0000_0300, 32'hDEAD_BEEF, 4'hF});
        mem_write = 1'b1; mem_addr = 32'h300; mem_wdata = 32'hDEAD_BEEF; mem_wstrb = 4'hF;
        cyc();
        mem_write = 1'b0; mem_wdata = 32'd0; mem_wstrb = 4'd0; bus_req_ack = 1'b1; #1;
        n_vec++;
        if (bus_req_wr !== 1'b1 || bus_wstrb !== 4'hF || bus_wdata !== 32'hDEAD_BEEF || mem_req_ack !== 1'b1) begin
            n_err++;
            $display("FAIL store_req: got wr=%b s=%h d=%h ack=%b expected 1/f/deadbeef/1",
                     bus_req_wr, bus_wstrb, bus_wdata, mem_req_ack);
        end
        cyc();
        bus_req_ack = 1'b0; bus_resp_valid = 1'b1; read_data_ack = 1'b1; #1;
        n_vec++;
        if (bus_req_valid !== 1'b0 || read_data_valid !== 1'b0 || bus_resp_ack !== 1'b0) begin
            n_err++;
            $display("FAIL store_no_resp: got req=%b rdv=%b rack=%b expected 0/0/0",
                     bus_req_valid, read_data_valid, bus_resp_ack);
        end
        cyc();
        bus_resp_valid = 1'b0; read_data_ack = 1'b0;
        do_store(32'h304, 32'h0000_CAFE, 4'h3, 1, 1'b1);
    endtask

    task automatic test_load_hold();
        exp_bus_q.push_back('{1'b0, 32'h0000_0500, 32'd0, 4'd0});
        exp_rsp_q.push_back('{1'b0, 32'h1234_5678});
        mem_read = 1'b1; mem_addr = 32'h500;
        cyc();
        mem_read = 1'b0; bus_req_ack = 1'b1;
        cyc();
        bus_req_ack = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = 32'h1234_5678; read_data_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (bus_resp_ack !== 1'b0 || read_data_valid !== 1'b1 || read_data !== 32'h1234_5678) begin
                n_err++;
                $display("FAIL load_hold[%0d]: got rack=%b rdv=%b d=%h expected 0/1/12345678",
                         i, bus_resp_ack, read_data_valid, read_data);
            end
            cyc();
        end
        read_data_ack = 1'b1; #1;
        n_vec++;
        if (bus_resp_ack !== 1'b1) begin
            n_err++;
            $display("FAIL load_ack: got %b expected 1", bus_resp_ack);
        end
        cyc();
        bus_resp_valid = 1'b0; read_data_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_bus_q.push_back('{1'b0, 32'h0000_0600, 32'd0, 4'd0});
        inst_req_valid = 1'b1; inst_addr = 32'h600;
        cyc();
        inst_req_valid = 1'b0; bus_req_ack = 1'b1;
        cyc();
        bus_req_ack = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = 32'h5555_5555; rst = 1'b1;
        cyc();
        rst = 1'b0; inst_ack = 1'b1; read_data_ack = 1'b1; #1;
        n_vec++;
        if ({bus_req_valid, inst_req_ack, mem_req_ack, inst_valid, read_data_valid,
             bus_resp_ack} !== 6'b0 || bus_addr !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid: got ctrl=%b a=%h expected 000000/0", {bus_req_valid,
                     inst_req_ack, mem_req_ack, inst_valid, read_data_valid, bus_resp_ack}, bus_addr);
        end
        cyc();
        clear_inputs();
        do_load(32'h700, 32'h0BAD_F00D);
    endtask

`ifdef ARB_PERF_CNT_EN
    task automatic test_perf();
        rst = 1'b1;
        cyc();
        rst = 1'b0; #1;
        n_vec++;
        if ({perf_inst_cnt, perf_data_cnt, perf_stall_cnt} !== 96'd0) begin
            n_err++;
            $display("FAIL perf_reset: got %h/%h/%h expected 0", perf_inst_cnt, perf_data_cnt, perf_stall_cnt);
        end
        do_fetch(32'h800, 32'h0000_0001, 1);
        do_fetch(32'h804, 32'h0000_0002, 0);
        do_store(32'h900, 32'h0000_00FF, 4'h1, 2, 1'b0);
        cyc(); #1;
        n_vec++;
        if (perf_inst_cnt !== 32'd2 || perf_data_cnt !== 32'd1 || perf_stall_cnt !== 32'd3) begin
            n_err++;
            $display("FAIL perf_counts: got %0d/%0d/%0d expected 2/1/3",
                     perf_inst_cnt, perf_data_cnt, perf_stall_cnt);
        end
    endtask
`endif

    task automatic test_back_to_back();
        do_fetch(32'hA00, 32'h0000_0A0A, 0);
        do_store(32'hB00, 32'h1111_2222, 4'hC, 0, 1'b0);
        do_load(32'hC00, 32'h3333_4444);
        #1;
        n_vec++;
        if (bus_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end_idle: got req=%b expected 0", bus_req_valid);
        end
        cyc();
    endtask

    task automatic test_scoreboard();
        bus_txn_t eb, ob;
        rsp_t     er, orr;
        n_vec++;
        if (obs_bus_q.size() != exp_bus_q.size()) begin
            n_err++;
            $display("FAIL sb_bus_count: got %0d expected %0d", obs_bus_q.size(), exp_bus_q.size());
        end
        while (exp_bus_q.size() > 0 && obs_bus_q.size() > 0) begin
            eb = exp_bus_q.pop_front();
            ob = obs_bus_q.pop_front();
            n_vec++;
            if (ob !== eb) begin
                n_err++;
                $display("FAIL sb_bus: got wr=%b a=%h d=%h s=%h expected wr=%b a=%h d=%h s=%h",
                         ob.wr, ob.addr, ob.wdata, ob.wstrb, eb.wr, eb.addr, eb.wdata, eb.wstrb);
            end
        end
        n_vec++;
        if (obs_rsp_q.size() != exp_rsp_q.size()) begin
            n_err++;
            $display("FAIL sb_rsp_count: got %0d expected %0d", obs_rsp_q.size(), exp_rsp_q.size());
        end
        while (exp_rsp_q.size() > 0 && obs_rsp_q.size() > 0) begin
            er  = exp_rsp_q.pop_front();
            orr = obs_rsp_q.pop_front();
            n_vec++;
            if (orr !== er) begin
                n_err++;
                $display("FAIL sb_rsp: got inst=%b d=%h expected inst=%b d=%h",
                         orr.is_inst, orr.data, er.is_inst, er.data);
            end
        end
    endtask

    // Test sequence.
    initial begin
        rst = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        test_reset();
        rst = 1'b0;
        cyc();
        test_fetch();
        test_priority();
        test_store();
        test_load_hold();
        test_reset_mid();
`ifdef ARB_PERF_CNT_EN
        test_perf();
`endif
        test_back_to_back();
        test_scoreboard();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
